// File: rtl/io_2to1_pkg.sv
// Shared definitions for the io_2to1 merge harness: channel field widths,
// debounce depths, FSM state types and the sequence-number helper.
package io_2to1_pkg;

    localparam int unsigned NsAddressSize = 6;
    localparam int unsigned NsDataSize    = 8;
    localparam int unsigned NsRedunSize   = 4;

    // Debounce depth in clocks for raw ack/req handshake inputs.
    localparam int unsigned NsAckCks = 2;
    localparam int unsigned NsReqCks = 2;

    typedef enum logic [1:0] {
        SLoad,
        SRed,
        SReq,
        SRel
    } src_state_e;

    typedef enum logic [1:0] {
        RWait,
        RRed,
        RChk,
        RAck
    } snk_state_e;

    // Next expected 4-bit sequence number, wrapping 15 -> 0.
    function automatic logic [3:0] seq_next(input logic [3:0] n);
        return n + 4'd1;
    endfunction

endpackage

// File: rtl/calc_redun.sv
// Redundancy code over a message: XOR-fold of {src, dst, dat} into RSZ bits,
// with the top chunk zero-padded when the message width is not a multiple of RSZ.
module calc_redun #(
    parameter int unsigned ASZ = 6,
    parameter int unsigned DSZ = 8,
    parameter int unsigned RSZ = 4
) (
    input  logic [ASZ-1:0] src_i,
    input  logic [ASZ-1:0] dst_i,
    input  logic [DSZ-1:0] dat_i,
    output logic [RSZ-1:0] redun_o
);

    localparam int unsigned Width  = 2 * ASZ + DSZ;
    localparam int unsigned Chunks = (Width + RSZ - 1) / RSZ;

    logic [Chunks*RSZ-1:0] padded;

    assign padded = (Chunks * RSZ)'({src_i, dst_i, dat_i});

    // Fold all RSZ-bit chunks together.
    always_comb begin
        redun_o = '0;
        for (int c = 0; c < Chunks; c++) begin
            redun_o = redun_o ^ padded[c*RSZ +: RSZ];
        end
    end

endmodule

// File: rtl/io_src_gen.sv
// One numbered-message source: debounced ack, 4-bit message counter, and a
// four-state load/redundancy/request/release handshake FSM.
module io_src_gen
    import io_2to1_pkg::*;
#(
    parameter int unsigned    ASZ      = NsAddressSize,
    parameter int unsigned    DSZ      = NsDataSize,
    parameter int unsigned    RSZ      = NsRedunSize,
    parameter logic [ASZ-1:0] SRC_ADDR = ASZ'(9),
    parameter logic [ASZ-1:0] DST_ADDR = ASZ'(1)
) (
    input  logic           clk_i,
    input  logic           reset_i,
    output logic [ASZ-1:0] src_o,
    output logic [ASZ-1:0] dst_o,
    output logic [DSZ-1:0] dat_o,
    output logic [RSZ-1:0] red_o,
    output logic           req_o,
    input  logic           ack_i
);

    logic [NsAckCks-1:0] ack_sync_q;
    logic                ckd_ack;

    src_state_e     state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [ASZ-1:0] src_q, src_d;
    logic [ASZ-1:0] dst_q, dst_d;
    logic [DSZ-1:0] dat_q, dat_d;
    logic [RSZ-1:0] red_q, red_d;
    logic           req_q, req_d;
    logic [RSZ-1:0] red_calc;

    assign ckd_ack = ack_sync_q[NsAckCks-1];

    calc_redun #(
        .ASZ(ASZ),
        .DSZ(DSZ),
        .RSZ(RSZ)
    ) u_calc_redun (
        .src_i  (src_q),
        .dst_i  (dst_q),
        .dat_i  (dat_q),
        .redun_o(red_calc)
    );

    // Debounce the raw ack through a short shift register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q[0] <= ack_i;
            for (int i = 1; i < int'(NsAckCks); i++) begin
                ack_sync_q[i] <= ack_sync_q[i-1];
            end
        end
    end

    // Source state and message registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= SLoad;
            cnt_q   <= '0;
            src_q   <= SRC_ADDR;
            dst_q   <= DST_ADDR;
            dat_q   <= '0;
            red_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            dat_q   <= dat_d;
            red_q   <= red_d;
            req_q   <= req_d;
        end
    end

    // Next-state: fields change only before req rises and after it falls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        dat_d   = dat_q;
        red_d   = red_q;
        req_d   = req_q;
        unique case (state_q)
            SLoad: begin
                // A stuck-high ack parks the source here.
                if (!ckd_ack) begin
                    dat_d   = DSZ'(cnt_q);
                    src_d   = SRC_ADDR;
                    dst_d   = DST_ADDR;
                    state_d = SRed;
                end
            end
            SRed: begin
                red_d   = red_calc;
                req_d   = 1'b1;
                state_d = SReq;
            end
            SReq: begin
                if (ckd_ack) begin
                    req_d   = 1'b0;
                    cnt_d   = cnt_q + 4'd1;
                    state_d = SRel;
                end
            end
            SRel: begin
                if (!ckd_ack) begin
                    state_d = SLoad;
                end
            end
            default: state_d = SLoad;
        endcase
    end

    assign src_o = src_q;
    assign dst_o = dst_q;
    assign dat_o = dat_q;
    assign red_o = red_q;
    assign req_o = req_q;

endmodule

// File: rtl/io_2to1.sv
// Harness for a 2-to-1 message merge: two independent numbered sources on
// o0/o1 and a checking sink on i0 that flags address, redundancy and
// per-source sequence errors on dbg_leds.
// Optional: define IO_2TO1_DBG_DISP_EN to show the last checked sequence
// number of each source on dbg_disp0/dbg_disp1; otherwise both are tied to 0.
module io_2to1
    import io_2to1_pkg::*;
#(
    parameter int unsigned    ASZ       = NsAddressSize,
    parameter int unsigned    DSZ       = NsDataSize,
    parameter int unsigned    RSZ       = NsRedunSize,
    parameter logic [ASZ-1:0] SRC0_ADDR = ASZ'(9),
    parameter logic [ASZ-1:0] SRC1_ADDR = ASZ'(10),
    parameter logic [ASZ-1:0] DST_ADDR  = ASZ'(1)
) (
    input  logic           clk,
    input  logic           reset,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req_out,
    input  logic           o0_ack_in,
    output logic [ASZ-1:0] o1_src,
    output logic [ASZ-1:0] o1_dst,
    output logic [DSZ-1:0] o1_dat,
    output logic [RSZ-1:0] o1_red,
    output logic           o1_req_out,
    input  logic           o1_ack_in,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req_in,
    output logic           i0_ack_out,
    output logic [3:0]     dbg_leds,
    output logic [3:0]     dbg_disp0,
    output logic [3:0]     dbg_disp1
);

    io_src_gen #(
        .ASZ     (ASZ),
        .DSZ     (DSZ),
        .RSZ     (RSZ),
        .SRC_ADDR(SRC0_ADDR),
        .DST_ADDR(DST_ADDR)
    ) u_src0 (
        .clk_i  (clk),
        .reset_i(reset),
        .src_o  (o0_src),
        .dst_o  (o0_dst),
        .dat_o  (o0_dat),
        .red_o  (o0_red),
        .req_o  (o0_req_out),
        .ack_i  (o0_ack_in)
    );

    io_src_gen #(
        .ASZ     (ASZ),
        .DSZ     (DSZ),
        .RSZ     (RSZ),
        .SRC_ADDR(SRC1_ADDR),
        .DST_ADDR(DST_ADDR)
    ) u_src1 (
        .clk_i  (clk),
        .reset_i(reset),
        .src_o  (o1_src),
        .dst_o  (o1_dst),
        .dat_o  (o1_dat),
        .red_o  (o1_red),
        .req_o  (o1_req_out),
        .ack_i  (o1_ack_in)
    );

    logic [NsReqCks-1:0] req_sync_q;
    logic                ckd_req;

    snk_state_e     snk_q, snk_d;
    logic [ASZ-1:0] rsrc_q, rsrc_d;
    logic [ASZ-1:0] rdst_q, rdst_d;
    logic [DSZ-1:0] rdat_q, rdat_d;
    logic [RSZ-1:0] rred_q, rred_d;
    logic [RSZ-1:0] cred_q, cred_d;
    logic [RSZ-1:0] red_calc;
    logic           ack_q, ack_d;
    logic [3:0]     exp0_q, exp0_d;
    logic [3:0]     exp1_q, exp1_d;
    logic           err_adr_q, err_adr_d;
    logic           err_red_q, err_red_d;
    logic           err_seq0_q, err_seq0_d;
    logic           err_seq1_q, err_seq1_d;

    assign ckd_req = req_sync_q[NsReqCks-1];

    calc_redun #(
        .ASZ(ASZ),
        .DSZ(DSZ),
        .RSZ(RSZ)
    ) u_calc_redun (
        .src_i  (rsrc_q),
        .dst_i  (rdst_q),
        .dat_i  (rdat_q),
        .redun_o(red_calc)
    );

    // Debounce the raw sink req through a short shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_sync_q <= '0;
        end else begin
            req_sync_q[0] <= i0_req_in;
            for (int i = 1; i < int'(NsReqCks); i++) begin
                req_sync_q[i] <= req_sync_q[i-1];
            end
        end
    end

    // Sink state, latched message, expected sequence numbers and sticky errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            snk_q      <= RWait;
            rsrc_q     <= '0;
            rdst_q     <= '0;
            rdat_q     <= '0;
            rred_q     <= '0;
            cred_q     <= '0;
            ack_q      <= 1'b0;
            exp0_q     <= '0;
            exp1_q     <= '0;
            err_adr_q  <= 1'b0;
            err_red_q  <= 1'b0;
            err_seq0_q <= 1'b0;
            err_seq1_q <= 1'b0;
        end else begin
            snk_q      <= snk_d;
            rsrc_q     <= rsrc_d;
            rdst_q     <= rdst_d;
            rdat_q     <= rdat_d;
            rred_q     <= rred_d;
            cred_q     <= cred_d;
            ack_q      <= ack_d;
            exp0_q     <= exp0_d;
            exp1_q     <= exp1_d;
            err_adr_q  <= err_adr_d;
            err_red_q  <= err_red_d;
            err_seq0_q <= err_seq0_d;
            err_seq1_q <= err_seq1_d;
        end
    end

    // Sink next-state and checks.
    always_comb begin
        snk_d      = snk_q;
        rsrc_d     = rsrc_q;
        rdst_d     = rdst_q;
        rdat_d     = rdat_q;
        rred_d     = rred_q;
        cred_d     = cred_q;
        ack_d      = ack_q;
        exp0_d     = exp0_q;
        exp1_d     = exp1_q;
        err_adr_d  = err_adr_q;
        err_red_d  = err_red_q;
        err_seq0_d = err_seq0_q;
        err_seq1_d = err_seq1_q;
        unique case (snk_q)
            RWait: begin
                if (ckd_req) begin
                    rsrc_d = i0_src;
                    rdst_d = i0_dst;
                    rdat_d = i0_dat;
                    rred_d = i0_red;
                    snk_d  = RRed;
                end
            end
            RRed: begin
                cred_d = red_calc;
                snk_d  = RChk;
            end
            RChk: begin
                if (rdst_q != DST_ADDR) begin
                    err_adr_d = 1'b1;
                end
                if (rred_q != cred_q) begin
                    err_red_d = 1'b1;
                end
                // Expected value always resyncs to the received one, so a gap
                // is flagged once rather than on every later message.
                if (rsrc_q == SRC0_ADDR) begin
                    if (rdat_q[3:0] != exp0_q) begin
                        err_seq0_d = 1'b1;
                    end
                    exp0_d = seq_next(rdat_q[3:0]);
                end else if (rsrc_q == SRC1_ADDR) begin
                    if (rdat_q[3:0] != exp1_q) begin
                        err_seq1_d = 1'b1;
                    end
                    exp1_d = seq_next(rdat_q[3:0]);
                end else begin
                    err_adr_d = 1'b1;
                end
                ack_d = 1'b1;
                snk_d = RAck;
            end
            RAck: begin
                if (!ckd_req) begin
                    ack_d = 1'b0;
                    snk_d = RWait;
                end
            end
            default: snk_d = RWait;
        endcase
    end

    assign i0_ack_out = ack_q;
    assign dbg_leds   = {err_red_q, err_seq1_q, err_seq0_q, err_adr_q};

`ifdef IO_2TO1_DBG_DISP_EN
    logic [3:0] disp0_q;
    logic [3:0] disp1_q;

    // Capture the sequence number of each checked valid-source message.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp0_q <= '0;
            disp1_q <= '0;
        end else if (snk_q == RChk) begin
            if (rsrc_q == SRC0_ADDR) begin
                disp0_q <= rdat_q[3:0];
            end else if (rsrc_q == SRC1_ADDR) begin
                disp1_q <= rdat_q[3:0];
            end
        end
    end

    assign dbg_disp0 = disp0_q;
    assign dbg_disp1 = disp1_q;
`else
    assign dbg_disp0 = 4'd0;
    assign dbg_disp1 = 4'd0;
`endif

endmodule

// File: tb/tb_io_2to1.sv
// Directed bench for io_2to1: acts as the merge stage between o0/o1 and i0,
// with hooks to drop, corrupt or inject messages.
module tb_io_2to1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] o0_src, o0_dst, o1_src, o1_dst;
    logic [7:0] o0_dat, o1_dat;
    logic [3:0] o0_red, o1_red;
    logic       o0_req_out, o1_req_out;
    logic       o0_ack_in = 1'b0;
    logic       o1_ack_in = 1'b0;
    logic [5:0] i0_src = '0;
    logic [5:0] i0_dst = '0;
    logic [7:0] i0_dat = '0;
    logic [3:0] i0_red = '0;
    logic       i0_req_in = 1'b0;
    logic       i0_ack_out;
    logic [3:0] dbg_leds, dbg_disp0, dbg_disp1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    io_2to1 dut (
        .clk       (clk),
        .reset     (reset),
        .o0_src    (o0_src),
        .o0_dst    (o0_dst),
        .o0_dat    (o0_dat),
        .o0_red    (o0_red),
        .o0_req_out(o0_req_out),
        .o0_ack_in (o0_ack_in),
        .o1_src    (o1_src),
        .o1_dst    (o1_dst),
        .o1_dat    (o1_dat),
        .o1_red    (o1_red),
        .o1_req_out(o1_req_out),
        .o1_ack_in (o1_ack_in),
        .i0_src    (i0_src),
        .i0_dst    (i0_dst),
        .i0_dat    (i0_dat),
        .i0_red    (i0_red),
        .i0_req_in (i0_req_in),
        .i0_ack_out(i0_ack_out),
        .dbg_leds  (dbg_leds),
        .dbg_disp0 (dbg_disp0),
        .dbg_disp1 (dbg_disp1)
    );

    // Redundancy: XOR of the five nibbles of {src, dst, dat}.
    function automatic logic [3:0] red_model(input logic [5:0] s, input logic [5:0] d,
                                             input logic [7:0] x);
        logic [19:0] w;
        w = {s, d, x};
        return w[3:0] ^ w[7:4] ^ w[11:8] ^ w[15:12] ^ w[19:16];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic src_req(input int s);
        return (s == 0) ? o0_req_out : o1_req_out;
    endfunction

    task automatic set_ack(input int s, input logic v);
        if (s == 0) o0_ack_in = v;
        else o1_ack_in = v;
    endtask

    task automatic wait_src_req(input int s, input logic lvl, input string tag);
        int n = 0;
        while (src_req(s) !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(src_req(s)), 32'(lvl));
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (i0_ack_out !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(i0_ack_out), 32'(lvl));
    endtask

    // Forward one message into the sink and complete its handshake.
    task automatic send(input logic [5:0] s, input logic [5:0] d, input logic [7:0] x,
                        input logic [3:0] r);
        i0_src    = s;
        i0_dst    = d;
        i0_dat    = x;
        i0_red    = r;
        i0_req_in = 1'b1;
        wait_ack(1'b1, "sink_ack_rise");
        i0_req_in = 1'b0;
        wait_ack(1'b0, "sink_ack_fall");
    endtask

    // Take one message from source s, optionally drop it or flip red bit 0.
    task automatic relay(input int s, input int exp_dat, input bit drop, input bit bad_red);
        logic [5:0] sa, da;
        logic [7:0] x;
        logic [3:0] r;
        wait_src_req(s, 1'b1, "src_req_rise");
        if (s == 0) begin
            sa = o0_src; da = o0_dst; x = o0_dat; r = o0_red;
        end else begin
            sa = o1_src; da = o1_dst; x = o1_dat; r = o1_red;
        end
        chk("msg_src", 32'(sa), (s == 0) ? 32'd9 : 32'd10);
        chk("msg_dst", 32'(da), 32'd1);
        chk("msg_dat", 32'(x), 32'(exp_dat));
        chk("msg_red", 32'(r), 32'(red_model(sa, da, x)));
        if (!drop) send(sa, da, x, bad_red ? (r ^ 4'b0001) : r);
        set_ack(s, 1'b1);
        wait_src_req(s, 1'b0, "src_req_fall");
        set_ack(s, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        o0_ack_in = 1'b0;
        o1_ack_in = 1'b0;
        i0_req_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_o0_req", 32'(o0_req_out), 32'd0);
        chk("rst_o1_req", 32'(o1_req_out), 32'd0);
        chk("rst_o0_dat", 32'(o0_dat), 32'd0);
        chk("rst_o1_red", 32'(o1_red), 32'd0);
        chk("rst_o0_src", 32'(o0_src), 32'd9);
        chk("rst_o1_src", 32'(o1_src), 32'd10);
        chk("rst_o0_dst", 32'(o0_dst), 32'd1);
        chk("rst_ack", 32'(i0_ack_out), 32'd0);
        chk("rst_leds", 32'(dbg_leds), 32'd0);
        chk("rst_disp", 32'({dbg_disp0, dbg_disp1}), 32'd0);
        reset = 1'b0;

        // Fair loopback: 32 messages per source, data wraps 0..15 twice.
        for (int k = 0; k < 32; k++) begin
            relay(0, k % 16, 1'b0, 1'b0);
            relay(1, k % 16, 1'b0, 1'b0);
        end
        chk("loop_leds", 32'(dbg_leds), 32'd0);

        // Drop source-0 dat=5: dat=6 flags err_seq0, dat=7 resyncs cleanly.
        for (int k = 0; k < 5; k++) relay(0, k, 1'b0, 1'b0);
        chk("pre_drop_leds", 32'(dbg_leds), 32'd0);
        relay(0, 5, 1'b1, 1'b0);
        relay(0, 6, 1'b0, 1'b0);
        chk("drop_leds", 32'(dbg_leds), 32'b0010);
        relay(0, 7, 1'b0, 1'b0);
        chk("resync_leds", 32'(dbg_leds), 32'b0010);

        // Corrupt red bit 0 on one message.
        do_reset();
        chk("post_rst_leds", 32'(dbg_leds), 32'd0);
        relay(0, 0, 1'b0, 1'b1);
        chk("red_leds", 32'(dbg_leds), 32'b1000);
        relay(1, 0, 1'b0, 1'b0);
        chk("red_leds2", 32'(dbg_leds), 32'b1000);

        // Invalid source: address error, expected counters untouched.
        do_reset();
        send(6'd3, 6'd1, 8'd7, red_model(6'd3, 6'd1, 8'd7));
        chk("adr_leds", 32'(dbg_leds), 32'b0001);
        relay(0, 0, 1'b0, 1'b0);
        relay(1, 0, 1'b0, 1'b0);
        chk("adr_exp_kept", 32'(dbg_leds), 32'b0001);

        // Both acks held high, then released together.
        wait_src_req(0, 1'b1, "hold_req0_up");
        wait_src_req(1, 1'b1, "hold_req1_up");
        o0_ack_in = 1'b1;
        o1_ack_in = 1'b1;
        wait_src_req(0, 1'b0, "hold_req0_fall");
        wait_src_req(1, 1'b0, "hold_req1_fall");
        repeat (10) @(negedge clk);
        chk("hold_reqs_low", 32'({o0_req_out, o1_req_out}), 32'd0);
        o0_ack_in = 1'b0;
        o1_ack_in = 1'b0;
        // Two debounce clocks, one to re-enter load, two more to request.
        repeat (4) @(negedge clk);
        chk("rel_reqs_c4", 32'({o0_req_out, o1_req_out}), 32'd0);
        @(negedge clk);
        chk("rel_reqs_c5", 32'({o0_req_out, o1_req_out}), 32'b11);

        // Reset mid-handshake; sink ack timing checked on the way in.
        i0_src    = 6'd9;
        i0_dst    = 6'd1;
        i0_dat    = 8'd0;
        i0_red    = red_model(6'd9, 6'd1, 8'd0);
        i0_req_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("snk_ack_c4", 32'(i0_ack_out), 32'd0);
        @(negedge clk);
        chk("snk_ack_c5", 32'(i0_ack_out), 32'd1);
        chk("mid_o0_req", 32'(o0_req_out), 32'd1);
        reset     = 1'b1;
        i0_req_in = 1'b0;
        @(negedge clk);
        chk("mid_rst_reqs", 32'({o0_req_out, o1_req_out}), 32'd0);
        chk("mid_rst_ack", 32'(i0_ack_out), 32'd0);
        chk("mid_rst_leds", 32'(dbg_leds), 32'd0);
        reset = 1'b0;
        relay(0, 0, 1'b0, 1'b0);
        relay(1, 0, 1'b0, 1'b0);
        chk("after_rst_leds", 32'(dbg_leds), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
